// File: rtl/spin_sequencer.sv
// spin_sequencer: LED spinner. Steps a one-hot 4-LED pattern (bounce, rotate-left,
// rotate-right or hold) once per dwell period of prescaled ticks, with pause/resume
// and a config handshake that is only open while idle or paused.
module spin_sequencer #(
   parameter int unsigned PRESCALE_W = 16,
   parameter int unsigned DWELL_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  run,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [1:0]            cfg_mode,
   input  logic [DWELL_W-1:0]    cfg_dwell,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   output logic [3:0]            leds,
   output logic                  blink,
   output logic                  step_pulse,
   output logic [7:0]            step_count,
   output logic [1:0]            state_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      STEP  = 2'b01,
      WAIT  = 2'b10,
      PAUSE = 2'b11
   } state_e;

   localparam logic [1:0] MODE_BOUNCE = 2'd0;
   localparam logic [1:0] MODE_ROTL   = 2'd1;
   localparam logic [1:0] MODE_ROTR   = 2'd2;

   state_e                  state_q, state_d;
   logic [1:0]              mode_q, mode_d;
   logic [DWELL_W-1:0]      dwell_q, dwell_d;
   logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
   // Prescale limit in use by the current dwell; a config taken in PAUSE
   // must not disturb the in-flight wait, so this is only loaded on a step.
   logic [PRESCALE_W-1:0]   lim_q, lim_d;
   logic [DWELL_W-1:0]      timer_q, timer_d;
   logic [PRESCALE_W-1:0]   pre_q, pre_d;
   logic [3:0]              leds_q, leds_d;
   logic                    dir_up_q, dir_up_d;
   logic                    blink_q, blink_d;
   logic                    pulse_q, pulse_d;
   logic [7:0]              count_q, count_d;
   logic                    ready_q, ready_d;

   // Next-state, config latch, wait timing and step side effects.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      dwell_d    = dwell_q;
      prescale_d = prescale_q;
      lim_d      = lim_q;
      timer_d    = timer_q;
      pre_d      = pre_q;
      leds_d     = leds_q;
      dir_up_d   = dir_up_q;
      blink_d    = blink_q;
      count_d    = count_q;

      if (cfg_valid && ready_q) begin
         mode_d     = cfg_mode;
         dwell_d    = cfg_dwell;
         prescale_d = cfg_prescale;
      end

      case (state_q)
         IDLE:  if (run) state_d = STEP;
         STEP:  state_d = WAIT;
         WAIT: begin
            if (!run) begin
               state_d = PAUSE;
            end else if (timer_q == '0) begin
               state_d = STEP;
            end else if (pre_q == lim_q) begin
               pre_d   = '0;
               timer_d = timer_q - DWELL_W'(1);
            end else begin
               pre_d = pre_q + PRESCALE_W'(1);
            end
         end
         PAUSE: if (run) state_d = WAIT;
         default: state_d = IDLE;
      endcase

      // Entering STEP: the step's visible effects appear during the STEP cycle.
      if (state_d == STEP) begin
         timer_d = dwell_d;
         lim_d   = prescale_d;
         pre_d   = '0;
         blink_d = ~blink_q;
         count_d = count_q + 8'd1;
         case (mode_d)
            MODE_BOUNCE: begin
               // A pattern left at the far edge by a rotate mode reflects
               // instead of shifting out to all-zero.
               if (dir_up_q) begin
                  if (leds_q[3]) begin
                     leds_d   = {1'b0, leds_q[3:1]};
                     dir_up_d = 1'b0;
                  end else begin
                     leds_d = {leds_q[2:0], 1'b0};
                  end
               end else begin
                  if (leds_q[0]) begin
                     leds_d   = {leds_q[2:0], 1'b0};
                     dir_up_d = 1'b1;
                  end else begin
                     leds_d = {1'b0, leds_q[3:1]};
                  end
               end
               if (leds_d == 4'b1000) dir_up_d = 1'b0;
               else if (leds_d == 4'b0001) dir_up_d = 1'b1;
            end
            MODE_ROTL: leds_d = {leds_q[2:0], leds_q[3]};
            MODE_ROTR: leds_d = {leds_q[0], leds_q[3:1]};
            default:   leds_d = leds_q;
         endcase
      end

      pulse_d = (state_d == STEP);
      ready_d = (state_d == IDLE) || (state_d == PAUSE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         mode_q     <= MODE_BOUNCE;
         dwell_q    <= DWELL_W'(250);
         prescale_q <= '1;
         lim_q      <= '1;
         timer_q    <= '0;
         pre_q      <= '0;
         leds_q     <= 4'b0001;
         dir_up_q   <= 1'b1;
         blink_q    <= 1'b0;
         pulse_q    <= 1'b0;
         count_q    <= 8'd0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         dwell_q    <= dwell_d;
         prescale_q <= prescale_d;
         lim_q      <= lim_d;
         timer_q    <= timer_d;
         pre_q      <= pre_d;
         leds_q     <= leds_d;
         dir_up_q   <= dir_up_d;
         blink_q    <= blink_d;
         pulse_q    <= pulse_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
      end
   end

   assign cfg_ready  = ready_q;
   assign leds       = leds_q;
   assign blink      = blink_q;
   assign step_pulse = pulse_q;
   assign step_count = count_q;
   assign state_out  = state_q;

endmodule

// File: tb/tb_spin_sequencer.sv
// Bench for spin_sequencer: cycle model compared every clock plus directed
// scenarios with hand-computed expectations.
module tb_spin_sequencer;

   logic        clk;
   logic        rst_l;
   logic        run;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [7:0]  cfg_dwell;
   logic [15:0] cfg_prescale;
   logic [3:0]  leds;
   logic        blink;
   logic        step_pulse;
   logic [7:0]  step_count;
   logic [1:0]  state_out;

   spin_sequencer dut (
      .clk(clk), .rst_l(rst_l), .run(run),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
      .cfg_dwell(cfg_dwell), .cfg_prescale(cfg_prescale),
      .leds(leds), .blink(blink), .step_pulse(step_pulse),
      .step_count(step_count), .state_out(state_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: phase 0 idle, 1 step, 2 wait, 3 pause; the wait is a
   // single budget of dwell*(prescale+1) active clocks; LEDs as a position.
   int m_ph, m_pos, m_cnt, m_rem, m_mode, m_dwell, m_pre;
   bit m_up, m_blink, m_pulse, m_go;

   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         m_ph = 0; m_pos = 0; m_up = 1; m_blink = 0; m_pulse = 0; m_cnt = 0;
         m_rem = 0; m_mode = 0; m_dwell = 250; m_pre = 65535;
      end else begin
         m_go = 0;
         if (cfg_valid && (m_ph == 0 || m_ph == 3)) begin
            m_mode = cfg_mode; m_dwell = cfg_dwell; m_pre = cfg_prescale;
         end
         case (m_ph)
            0: if (run) m_go = 1;
            1: m_ph = 2;
            2: if (!run) m_ph = 3; else if (m_rem == 0) m_go = 1; else m_rem--;
            default: if (run) m_ph = 2;
         endcase
         m_pulse = m_go;
         if (m_go) begin
            m_ph = 1;
            m_rem = m_dwell * (m_pre + 1);
            m_blink = !m_blink;
            m_cnt = (m_cnt + 1) % 256;
            case (m_mode)
               0: begin
                  if (m_up) begin
                     if (m_pos == 3) begin m_pos = 2; m_up = 0; end
                     else begin m_pos++; if (m_pos == 3) m_up = 0; end
                  end else begin
                     if (m_pos == 0) begin m_pos = 1; m_up = 1; end
                     else begin m_pos--; if (m_pos == 0) m_up = 1; end
                  end
               end
               1: m_pos = (m_pos + 1) % 4;
               2: m_pos = (m_pos + 3) % 4;
               default: ;
            endcase
         end
      end
   end

   // Compare DUT against the model every cycle.
   always @(posedge clk) begin
      #1;
      chk("state_out",  int'(state_out),  m_ph);
      chk("leds",       int'(leds),       1 << m_pos);
      chk("blink",      int'(blink),      int'(m_blink));
      chk("step_pulse", int'(step_pulse), int'(m_pulse));
      chk("step_count", int'(step_count), m_cnt);
      chk("cfg_ready",  int'(cfg_ready),  (m_ph == 0 || m_ph == 3) ? 1 : 0);
   end

   int p_leds [0:299];
   int p_cyc  [0:299];
   int p_cnt  [0:299];
   int p_blink[0:299];

   task automatic collect(input int n, input int budget);
      int got;
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         @(posedge clk); #2;
         if (step_pulse) begin
            p_leds[got] = leds; p_cyc[got] = cyc;
            p_cnt[got] = step_count; p_blink[got] = blink;
            got++;
         end
      end
      chk("pulse_budget", got, n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_l = 0; run = 0; cfg_valid = 0;
      @(negedge clk); @(negedge clk);
      rst_l = 1;
   endtask

   task automatic load_cfg(input int mode, input int dwell, input int pre);
      @(negedge clk);
      cfg_valid = 1; cfg_mode = 2'(mode); cfg_dwell = 8'(dwell); cfg_prescale = 16'(pre);
      @(negedge clk);
      cfg_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, np;
      rst_l = 1; run = 0; cfg_valid = 0; cfg_mode = 0; cfg_dwell = 0; cfg_prescale = 0;
      #3 rst_l = 0;
      #1;
      chk("rst_leds",  int'(leds), 1);
      chk("rst_state", int'(state_out), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      chk("rst_count", int'(step_count), 0);
      @(negedge clk); @(negedge clk);
      rst_l = 1;

      // Bounce, dwell 0, prescale 0.
      load_cfg(0, 0, 0);
      run = 1;
      collect(7, 40);
      for (int i = 0; i < 7; i++) begin
         int exp_l [0:6];
         exp_l = '{2, 4, 8, 4, 2, 1, 2};
         chk("bounce_leds", p_leds[i], exp_l[i]);
         chk("bounce_blink", p_blink[i], (i + 1) % 2);
         if (i > 0) chk("bounce_period", p_cyc[i] - p_cyc[i-1], 2);
      end

      // Rotate-left, dwell 3, prescale 1: period 8.
      do_reset();
      load_cfg(1, 3, 1);
      run = 1;
      collect(4, 60);
      for (int i = 0; i < 4; i++) begin
         int exp_l [0:3];
         exp_l = '{2, 4, 8, 1};
         chk("rotl_leds", p_leds[i], exp_l[i]);
         chk("rotl_count", p_cnt[i], i + 1);
         if (i > 0) chk("rotl_period", p_cyc[i] - p_cyc[i-1], 8);
      end

      // Rotate-right, dwell 5, prescale 0, pause mid-wait; ignored config in WAIT.
      do_reset();
      load_cfg(2, 5, 0);
      run = 1;
      collect(1, 10);
      chk("rotr_first_leds", p_leds[0], 8);
      @(negedge clk);
      cfg_valid = 1; cfg_mode = 0; cfg_dwell = 0; cfg_prescale = 0;
      @(negedge clk);
      cfg_valid = 0;
      @(negedge clk);
      run = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         chk("pause_state", int'(state_out), 3);
         chk("pause_ready", int'(cfg_ready), 1);
      end
      @(negedge clk);
      run = 1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #2;
         if (step_pulse) begin k = i; break; end
      end
      chk("resume_latency", k, 6);
      chk("rotr_second_leds", int'(leds), 4);

      // Pause again, switch to hold with dwell 1 while paused.
      @(negedge clk);
      run = 0;
      repeat (3) @(negedge clk);
      chk("pause2_ready", int'(cfg_ready), 1);
      cfg_valid = 1; cfg_mode = 3; cfg_dwell = 1; cfg_prescale = 0;
      @(negedge clk);
      cfg_valid = 0;
      run = 1;
      collect(4, 60);
      for (int i = 0; i < 4; i++) begin
         chk("hold_leds", p_leds[i], 4);
         chk("hold_blink", p_blink[i], (i + 1) % 2);
         if (i > 0) chk("hold_period", p_cyc[i] - p_cyc[i-1], 3);
      end
      collect(1, 10);
      chk("pre_rst_count", p_cnt[0], 7);
      chk("pre_rst_leds", p_leds[0], 4);

      // Asynchronous reset mid-WAIT.
      @(posedge clk); #3;
      rst_l = 0;
      #1;
      chk("async_leds",  int'(leds), 1);
      chk("async_count", int'(step_count), 0);
      chk("async_blink", int'(blink), 0);
      chk("async_state", int'(state_out), 0);
      chk("async_ready", int'(cfg_ready), 1);
      @(negedge clk); @(negedge clk);
      rst_l = 1;
      run = 1;
      np = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #2;
         if (step_pulse) begin
            if (np == 0) chk("cfg_reset_mode", int'(leds), 2);
            np++;
         end
      end
      chk("cfg_reset_dwell", np, 1);

      // step_count wrap.
      do_reset();
      load_cfg(0, 0, 0);
      run = 1;
      collect(256, 600);
      chk("wrap_255", p_cnt[254], 255);
      chk("wrap_0", p_cnt[255], 0);
      chk("wrap_leds_255", p_leds[254], 8);
      chk("wrap_leds_256", p_leds[255], 4);
      chk("wrap_period", p_cyc[255] - p_cyc[254], 2);

      // Reset during STEP drops the strobe immediately.
      collect(1, 10);
      rst_l = 0;
      #1;
      chk("step_rst_pulse", int'(step_pulse), 0);
      chk("step_rst_state", int'(state_out), 0);
      @(negedge clk);
      run = 0;
      @(negedge clk);
      rst_l = 1;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spin_sequencer.md
SPIN_SEQUENCER -- requirements
Module: spin_sequencer

Interface
REQ-001 Parameter PRESCALE_W, default 16: prescaler counter width.
REQ-002 Parameter DWELL_W, default 8: dwell timer width.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst_l  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 = sequence, 0 = pause/stop.
REQ-006 cfg_valid  input  1  config offer.
REQ-007 cfg_ready  output  1  config acceptance window.
REQ-008 cfg_mode  input  2  0 bounce, 1 rotate-left, 2 rotate-right, 3 hold.
REQ-009 cfg_dwell  input  DWELL_W  prescaler ticks per step.
REQ-010 cfg_prescale  input  PRESCALE_W  clocks per tick minus one.
REQ-011 leds  output  4  one-hot LED pattern.
REQ-012 blink  output  1  toggles on every step.
REQ-013 step_pulse  output  1  one-cycle strobe per step.
REQ-014 step_count  output  8  steps taken, wraps 255->0.
REQ-015 state_out  output  2  FSM state, encoded for analyzer probing.

Function
REQ-016 FSM states and encodings SHALL be IDLE=00, STEP=01, WAIT=10, PAUSE=11; state_out SHALL equal the current state.
REQ-017 IDLE: run=1 -> STEP next cycle; else stay.
REQ-018 STEP: lasts exactly one cycle; updates leds per mode, toggles blink, asserts step_pulse, increments step_count, loads dwell timer with latched dwell, clears prescaler; -> WAIT.
REQ-019 WAIT: run=0 -> PAUSE (timer and prescaler frozen); else if timer==0 -> STEP; else stay.
REQ-020 PAUSE: run=1 -> WAIT with frozen timer/prescaler values resumed; else stay.
REQ-021 Prescaler SHALL count 0..prescale in WAIT, wrapping to 0; tick asserted in the cycle count==prescale; prescale=0 gives a tick every clock.
REQ-022 Dwell timer SHALL decrement by 1 on each tick while nonzero, never wrapping below 0.
REQ-023 Step period with run held 1 SHALL be dwell*(prescale+1)+2 clocks; dwell=0 gives period 2.
REQ-024 cfg_ready SHALL be 1 exactly in IDLE and PAUSE; cfg_valid&&cfg_ready latches mode, dwell, prescale in that cycle.
REQ-025 A config accepted in PAUSE SHALL take effect at the next STEP; the in-flight timer is not reloaded.
REQ-026 Bounce: direction up shifts leds left, down shifts right; direction SHALL flip in the STEP that produces leds==1000 (up) or leds==0001 (down).
REQ-027 Rotate-left: leds<={leds[2:0],leds[3]}; rotate-right: leds<={leds[0],leds[3:1]}; direction register unchanged.
REQ-028 Hold: leds unchanged, blink still toggles, step_pulse and step_count still advance.
REQ-029 Mode change from rotate to bounce SHALL keep the current leds and direction register.
REQ-030 cfg_valid with cfg_ready=0 SHALL be ignored; no queueing.
REQ-031 run toggling in STEP SHALL not abort the step; it is sampled in the following state.

Reset
REQ-032 rst_l=0 SHALL immediately force: state IDLE, leds=0001, blink=0, step_pulse=0, step_count=0, direction up, timer=0, prescaler=0.
REQ-033 Latched config reset values: mode=0, dwell=250, prescale=all ones.
REQ-034 cfg_ready SHALL read 1 while in reset and after release (IDLE).
REQ-035 Reset asserted mid-WAIT or mid-STEP SHALL discard the step with no step_pulse emitted.

Verification
REQ-036 Reset, load mode=0 dwell=0 prescale=0, run=1 -> leds 0010,0100,1000,0100,0010,0001,0010, one step every 2 clocks, blink alternating.
REQ-037 Mode=1 dwell=3 prescale=1, run=1 -> step_pulse spacing 8 clocks; leds 0010,0100,1000,0001; step_count 1..4.
REQ-038 Mode=2 dwell=5 prescale=0; drop run 2 cycles into WAIT for 10 cycles, raise again -> state_out 11 held, cfg_ready=1, next step exactly 5 WAIT-clocks after STEP excluding pause.
REQ-039 In PAUSE offer mode=3 dwell=1 -> accepted same cycle; subsequent steps leave leds fixed, blink toggles, step period 3 clocks after first full dwell.
REQ-040 Assert rst_l=0 asynchronously mid-WAIT with leds=0100, step_count=7 -> outputs reach reset values before next clock edge; config back to 0/250/all ones.
REQ-041 Hold dwell=255 step_count past 255 with dwell=0 -> step_count wraps 255->0 without glitching leds.
